// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: observed lamp and 7-segment bus of the light controller.
// Signals: Red/Yellow/Green lamps, seg_a (tens) and seg_b (units) digits {a..g}, MSB=a.
// master drives the bus (controller or bench), slave observes it (monitor).
interface traffic_light_monitor_if;
  logic       Red;
  logic       Yellow;
  logic       Green;
  logic [6:0] seg_a;
  logic [6:0] seg_b;

  modport master (output Red, Yellow, Green, seg_a, seg_b);
  modport slave  (input  Red, Yellow, Green, seg_a, seg_b);
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: decodes the controller's lamps and 7-segment digits and checks
// countdown, phase sequence and phase duration legality. Latency: 2 cycles, input to flag.
// No backpressure: every clock is one sample. Optional macro TRAFFIC_MON_CYCLE_STATS_EN
// adds full_cycles (clean G,Y,R sequences).
// Ports: clk, rst (sync, active-high), en, clr_err, mon (lamp/segment bus, slave),
// count_dec, seg_valid, phase, phase_done, err_* pulses, err_sticky, err_total.
module traffic_light_monitor #(
  parameter int GREEN_INIT    = 14,
  parameter int YELLOW_INIT   = 2,
  parameter int RED_INIT      = 17,
  parameter int CNT_WIDTH     = 5,
  parameter int DUR_WIDTH     = 6,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr_err,
  traffic_light_monitor_if.slave   mon,
  output logic [CNT_WIDTH-1:0]     count_dec,
  output logic                     seg_valid,
  output logic [1:0]               phase,
  output logic                     phase_done,
  output logic                     err_onehot,
  output logic                     err_seq,
  output logic                     err_count,
  output logic                     err_dur,
  output logic                     err_seg,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_total
`ifdef TRAFFIC_MON_CYCLE_STATS_EN
  ,
  output logic [15:0]              full_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    RED    = 2'd3
  } state_t;

  localparam int CNT_MAX = (1 << CNT_WIDTH) - 1;

  // {valid, value}
  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    case (s)
      7'b1111110: seg_dec = 5'b1_0000;
      7'b0110000: seg_dec = 5'b1_0001;
      7'b1101101: seg_dec = 5'b1_0010;
      7'b1111001: seg_dec = 5'b1_0011;
      7'b0110011: seg_dec = 5'b1_0100;
      7'b1011011: seg_dec = 5'b1_0101;
      7'b1011111: seg_dec = 5'b1_0110;
      7'b1110000: seg_dec = 5'b1_0111;
      7'b1111111: seg_dec = 5'b1_1000;
      7'b1111011: seg_dec = 5'b1_1001;
      default:    seg_dec = 5'b0_0000;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] init_of(input state_t s);
    case (s)
      GREEN:   init_of = CNT_WIDTH'(GREEN_INIT);
      YELLOW:  init_of = CNT_WIDTH'(YELLOW_INIT);
      RED:     init_of = CNT_WIDTH'(RED_INIT);
      default: init_of = '0;
    endcase
  endfunction

  // A phase loaded with INIT counts INIT..0, i.e. INIT+1 samples.
  function automatic logic [DUR_WIDTH-1:0] dur_exp(input state_t s);
    case (s)
      GREEN:   dur_exp = DUR_WIDTH'(GREEN_INIT + 1);
      YELLOW:  dur_exp = DUR_WIDTH'(YELLOW_INIT + 1);
      RED:     dur_exp = DUR_WIDTH'(RED_INIT + 1);
      default: dur_exp = '0;
    endcase
  endfunction

  // ---------------- stage 1: input sample registers ----------------
  logic       en_q, clr_q, red_q, yel_q, grn_q;
  logic [6:0] sa_q, sb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      clr_q <= 1'b0;
      red_q <= 1'b0;
      yel_q <= 1'b0;
      grn_q <= 1'b0;
      sa_q  <= '0;
      sb_q  <= '0;
    end else begin
      en_q  <= en;
      clr_q <= clr_err;
      red_q <= mon.Red;
      yel_q <= mon.Yellow;
      grn_q <= mon.Green;
      sa_q  <= mon.seg_a;
      sb_q  <= mon.seg_b;
    end
  end

  // ---------------- decode of the stage-1 sample ----------------
  logic [4:0]           da, db;
  logic [7:0]           sum;
  logic                 dec_ok;
  logic [CNT_WIDTH-1:0] cnt_now;
  state_t               obs;

  assign da      = seg_dec(sa_q);
  assign db      = seg_dec(sb_q);
  assign sum     = {4'd0, da[3:0]} * 8'd10 + {4'd0, db[3:0]};
  assign dec_ok  = da[4] && db[4] && (int'(sum) <= CNT_MAX);
  assign cnt_now = CNT_WIDTH'(sum);

  // Not one-hot maps to IDLE, which doubles as the "bad lamp pattern" marker.
  always_comb begin
    case ({red_q, yel_q, grn_q})
      3'b100:  obs = RED;
      3'b010:  obs = YELLOW;
      3'b001:  obs = GREEN;
      default: obs = IDLE;
    endcase
  end

  // ---------------- tracking state and output registers ----------------
  state_t                   state_q, state_d;
  logic [DUR_WIDTH-1:0]     dur_q, dur_d, dur_inc;
  logic                     first_q, first_d;
  logic [CNT_WIDTH-1:0]     prev_cnt_q, prev_cnt_d;
  logic                     prev_vld_q, prev_vld_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     sv_q, sv_d;
  logic                     pdone_q, pdone_d;
  logic                     e_oh_q, e_oh_d, e_seq_q, e_seq_d, e_cnt_q, e_cnt_d;
  logic                     e_dur_q, e_dur_d, e_seg_q, e_seg_d;
  logic                     sticky_q, sticky_d;
  logic [ERR_CNT_WIDTH-1:0] total_q, total_d;
  logic                     err_any;
  logic                     legal;

  assign dur_inc = (dur_q == '1) ? dur_q : dur_q + DUR_WIDTH'(1);
  assign legal   = (state_q == GREEN  && obs == YELLOW) ||
                   (state_q == YELLOW && obs == RED)    ||
                   (state_q == RED    && obs == GREEN);

  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    first_d    = first_q;
    prev_cnt_d = prev_cnt_q;
    prev_vld_d = 1'b0;
    pdone_d    = 1'b0;
    e_oh_d     = 1'b0;
    e_seq_d    = 1'b0;
    e_cnt_d    = 1'b0;
    e_dur_d    = 1'b0;
    e_seg_d    = 1'b0;
    sv_d       = dec_ok;
    cnt_d      = dec_ok ? cnt_now : cnt_q;

    if (!en_q) begin
      state_d = IDLE;
      dur_d   = '0;
      first_d = 1'b0;
    end else begin
      e_seg_d = !dec_ok;
      if (obs == IDLE) begin
        // Bad lamp pattern: no phase decision this cycle. The sample still
        // occupies a slot of the current phase, and the count chain is broken
        // so the next sample is not compared against a stale value.
        e_oh_d = 1'b1;
        if (state_q != IDLE) dur_d = dur_inc;
      end else begin
        prev_vld_d = dec_ok;
        if (dec_ok) prev_cnt_d = cnt_now;
        if (state_q == IDLE) begin
          state_d = obs;
          e_seq_d = (obs != GREEN);
          dur_d   = DUR_WIDTH'(1);
          first_d = 1'b1;
        end else if (obs == state_q) begin
          dur_d = dur_inc;
          if (dec_ok && prev_vld_q)
            e_cnt_d = (prev_cnt_q == '0) || (cnt_now != prev_cnt_q - CNT_WIDTH'(1));
        end else begin
          state_d = obs;
          dur_d   = DUR_WIDTH'(1);
          first_d = 1'b0;
          if (legal) begin
            pdone_d = 1'b1;
            e_dur_d = !first_q && (dur_q != dur_exp(state_q));
          end else begin
            e_seq_d = 1'b1;
          end
          if ((prev_vld_q && prev_cnt_q != '0) || (dec_ok && cnt_now != init_of(obs)))
            e_cnt_d = 1'b1;
        end
      end
    end

    err_any = e_oh_d | e_seq_d | e_cnt_d | e_dur_d | e_seg_d;
    // A new error in the clearing cycle survives the clear.
    if (clr_q) begin
      sticky_d = err_any;
      total_d  = err_any ? ERR_CNT_WIDTH'(1) : '0;
    end else begin
      sticky_d = sticky_q | err_any;
      total_d  = (err_any && total_q != '1) ? total_q + ERR_CNT_WIDTH'(1) : total_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dur_q      <= '0;
      first_q    <= 1'b0;
      prev_cnt_q <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      sv_q       <= 1'b0;
      pdone_q    <= 1'b0;
      e_oh_q     <= 1'b0;
      e_seq_q    <= 1'b0;
      e_cnt_q    <= 1'b0;
      e_dur_q    <= 1'b0;
      e_seg_q    <= 1'b0;
      sticky_q   <= 1'b0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      first_q    <= first_d;
      prev_cnt_q <= prev_cnt_d;
      prev_vld_q <= prev_vld_d;
      cnt_q      <= cnt_d;
      sv_q       <= sv_d;
      pdone_q    <= pdone_d;
      e_oh_q     <= e_oh_d;
      e_seq_q    <= e_seq_d;
      e_cnt_q    <= e_cnt_d;
      e_dur_q    <= e_dur_d;
      e_seg_q    <= e_seg_d;
      sticky_q   <= sticky_d;
      total_q    <= total_d;
    end
  end

  assign count_dec  = cnt_q;
  assign seg_valid  = sv_q;
  assign phase      = state_q;
  assign phase_done = pdone_q;
  assign err_onehot = e_oh_q;
  assign err_seq    = e_seq_q;
  assign err_count  = e_cnt_q;
  assign err_dur    = e_dur_q;
  assign err_seg    = e_seg_q;
  assign err_sticky = sticky_q;
  assign err_total  = total_q;

`ifdef TRAFFIC_MON_CYCLE_STATS_EN
  // prog: 1 = in GREEN, 2 = legally in YELLOW, 3 = legally in RED.
  // clean drops on any error pulse since the GREEN entry that opened the sequence.
  logic [1:0]  prog_q, prog_d;
  logic        clean_q, clean_d;
  logic [15:0] fc_q, fc_d;

  always_comb begin
    prog_d  = prog_q;
    clean_d = clean_q & ~err_any;
    fc_d    = fc_q;
    if (!en_q) begin
      prog_d = 2'd0;
    end else if (state_d != state_q) begin
      if (state_d == GREEN) begin
        if (pdone_d && prog_q == 2'd3 && clean_q && !err_any) fc_d = fc_q + 16'd1;
        prog_d  = 2'd1;
        clean_d = ~err_any;
      end else if (pdone_d && state_d == YELLOW && prog_q == 2'd1) begin
        prog_d = 2'd2;
      end else if (pdone_d && state_d == RED && prog_q == 2'd2) begin
        prog_d = 2'd3;
      end else begin
        prog_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_q  <= 2'd0;
      clean_q <= 1'b0;
      fc_q    <= '0;
    end else begin
      prog_q  <= prog_d;
      clean_q <= clean_d;
      fc_q    <= fc_d;
    end
  end

  assign full_cycles = fc_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scoreboard bench for traffic_light_monitor.
// Each driven sample pushes its hand-derived expected outputs; they are popped and
// compared two cycles later when the monitor presents the result.
module tb_traffic_light_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr_err;
  logic [4:0] count_dec;
  logic       seg_valid;
  logic [1:0] phase;
  logic       phase_done, err_onehot, err_seq, err_count, err_dur, err_seg, err_sticky;
  logic [7:0] err_total;
`ifdef TRAFFIC_MON_CYCLE_STATS_EN
  logic [15:0] full_cycles;
`endif

  traffic_light_monitor_if lamp_if ();

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr_err    (clr_err),
    .mon        (lamp_if),
    .count_dec  (count_dec),
    .seg_valid  (seg_valid),
    .phase      (phase),
    .phase_done (phase_done),
    .err_onehot (err_onehot),
    .err_seq    (err_seq),
    .err_count  (err_count),
    .err_dur    (err_dur),
    .err_seg    (err_seg),
    .err_sticky (err_sticky),
    .err_total  (err_total)
`ifdef TRAFFIC_MON_CYCLE_STATS_EN
    ,
    .full_cycles(full_cycles)
`endif
  );

  // em bit order: {onehot, seq, count, dur, seg}
  typedef struct {
    logic [1:0] ph;
    logic       pd;
    logic [4:0] em;
    logic [4:0] cnt;
    logic       sv;
    logic       sticky;
    logic [7:0] total;
  } exp_t;

  exp_t       sbq[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic       exp_sticky = 1'b0;
  logic [7:0] exp_total  = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  task automatic compare_front();
    exp_t e;
    e = sbq.pop_front();
    check("phase",      32'(phase),      32'(e.ph));
    check("phase_done", 32'(phase_done), 32'(e.pd));
    check("err_onehot", 32'(err_onehot), 32'(e.em[4]));
    check("err_seq",    32'(err_seq),    32'(e.em[3]));
    check("err_count",  32'(err_count),  32'(e.em[2]));
    check("err_dur",    32'(err_dur),    32'(e.em[1]));
    check("err_seg",    32'(err_seg),    32'(e.em[0]));
    check("count_dec",  32'(count_dec),  32'(e.cnt));
    check("seg_valid",  32'(seg_valid),  32'(e.sv));
    check("err_sticky", 32'(err_sticky), 32'(e.sticky));
    check("err_total",  32'(err_total),  32'(e.total));
  endtask

  // Drive one sample and push what the monitor must report for it.
  task automatic vec(input logic e_n, input logic r, input logic y, input logic g,
                     input int c, input bit bad, input logic [1:0] ph, input logic pd,
                     input logic [4:0] em, input int ec, input logic sv,
                     input logic clr = 1'b0);
    exp_t x;
    @(negedge clk);
    if (sbq.size() == 2) compare_front();
    en             = e_n;
    clr_err        = clr;
    lamp_if.Red    = r;
    lamp_if.Yellow = y;
    lamp_if.Green  = g;
    lamp_if.seg_a  = seg_of(c / 10);
    lamp_if.seg_b  = bad ? 7'b0000001 : seg_of(c % 10);
    if (clr) begin
      exp_sticky = (em != 5'd0);
      exp_total  = (em != 5'd0) ? 8'd1 : 8'd0;
    end else begin
      exp_sticky = exp_sticky | (em != 5'd0);
      if (em != 5'd0 && exp_total != 8'hFF) exp_total = exp_total + 8'd1;
    end
    x.ph = ph; x.pd = pd; x.em = em; x.cnt = 5'(ec); x.sv = sv;
    x.sticky = exp_sticky; x.total = exp_total;
    sbq.push_back(x);
  endtask

  // Legal countdown in one phase, from..to; only the first sample may carry phase_done.
  task automatic run(input logic [1:0] ph, input int from, input int to, input logic pd0);
    for (int c = from; c >= to; c--)
      vec(1'b1, ph == 2'd3, ph == 2'd2, ph == 2'd1, c, 1'b0, ph,
          (c == from) ? pd0 : 1'b0, 5'b00000, c, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; clr_err = 1'b0;
    lamp_if.Red = 1'b0; lamp_if.Yellow = 1'b0; lamp_if.Green = 1'b0;
    lamp_if.seg_a = 7'd0; lamp_if.seg_b = 7'd0;
    sbq.delete();
    @(negedge clk);
    check("rst_phase",  32'(phase), 0);
    check("rst_cnt",    32'(count_dec), 0);
    check("rst_sv",     32'(seg_valid), 0);
    check("rst_pd",     32'(phase_done), 0);
    check("rst_errs",   32'({err_onehot, err_seq, err_count, err_dur, err_seg}), 0);
    check("rst_sticky", 32'(err_sticky), 0);
    check("rst_total",  32'(err_total), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_sticky = 1'b0;
    exp_total  = 8'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Two clean G,Y,R cycles, then GREEN again.
    run(2'd1, 14, 0, 1'b0); run(2'd2, 2, 0, 1'b1); run(2'd3, 17, 0, 1'b1);
    run(2'd1, 14, 0, 1'b1); run(2'd2, 2, 0, 1'b1); run(2'd3, 17, 0, 1'b1);

    // Countdown skip 11 -> 9.
    run(2'd1, 14, 11, 1'b1);
    vec(1, 0, 0, 1, 9, 0, 2'd1, 0, 5'b00100, 9, 1);
    run(2'd1, 8, 0, 1'b0);

    // GREEN -> RED: illegal sequence, resync to RED, countdown checked normally.
    vec(1, 1, 0, 0, 17, 0, 2'd3, 0, 5'b01000, 17, 1);
    run(2'd3, 16, 11, 1'b0);
    // Red and Green both lit for one sample.
    vec(1, 1, 0, 1, 10, 0, 2'd3, 0, 5'b10000, 10, 1);
    run(2'd3, 9, 0, 1'b0);

    // Legal exit from the resynced RED (18 samples incl. the glitch), then clear.
    run(2'd1, 14, 14, 1'b1);
    vec(1, 0, 0, 1, 13, 0, 2'd1, 0, 5'b00000, 13, 1, 1'b1);
    run(2'd1, 12, 11, 1'b0);
    // Undecodable units digit: count_dec holds 11.
    vec(1, 0, 0, 1, 10, 1, 2'd1, 0, 5'b00001, 11, 0);
    run(2'd1, 9, 0, 1'b0);

    // YELLOW stalls at 0 for two samples, RED then fails duration (5 != 3).
    run(2'd2, 2, 0, 1'b1);
    vec(1, 0, 1, 0, 0, 0, 2'd2, 0, 5'b00100, 0, 1);
    vec(1, 0, 1, 0, 0, 0, 2'd2, 0, 5'b00100, 0, 1);
    vec(1, 1, 0, 0, 17, 0, 2'd3, 1, 5'b00010, 17, 1);
    run(2'd3, 16, 15, 1'b0);
`ifdef TRAFFIC_MON_CYCLE_STATS_EN
    check("full_cycles", 32'(full_cycles), 2);
`endif
    do_reset();

    // Start in YELLOW from IDLE: err_seq; short first phase is exempt from err_dur.
    vec(1, 0, 1, 0, 1, 0, 2'd2, 0, 5'b01000, 1, 1);
    vec(1, 0, 1, 0, 0, 0, 2'd2, 0, 5'b00000, 0, 1);
    vec(1, 1, 0, 0, 17, 0, 2'd3, 1, 5'b00000, 17, 1);
    run(2'd3, 16, 0, 1'b0);
    run(2'd1, 14, 14, 1'b1);

    // Disabled: back to IDLE, no checks even with no lamp lit.
    for (int i = 0; i < 3; i++)
      vec(0, 0, 0, 0, 0, 0, 2'd0, 0, 5'b00000, 0, 1);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (sbq.size() != 0) compare_front();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Observer/checker at the output end of the traffic light controller; inverse of the 7-segment encoder and light FSM.
- Samples Red/Yellow/Green and the two 7-segment digit buses, decodes the segments back to a binary count, and tracks the phase sequence.
- Checks countdown, phase-sequence and phase-duration legality; flags violations.
- Used in board-level self-check and as a bench scoreboard.

Parameters:
- GREEN_INIT, 14, count value loaded at GREEN phase start
- YELLOW_INIT, 2, count value loaded at YELLOW phase start
- RED_INIT, 17, count value loaded at RED phase start
- CNT_WIDTH, 5, width of decoded count
- DUR_WIDTH, 6, width of per-phase cycle counter
- ERR_CNT_WIDTH, 8, width of error total counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  controller enable; monitor checks only while high
- clr_err  in  1  clears sticky error state
- Red  in  1  observed red lamp
- Yellow  in  1  observed yellow lamp
- Green  in  1  observed green lamp
- seg_a  in  7  tens digit, segments {a,b,c,d,e,f,g}, MSB=a, active-high
- seg_b  in  7  units digit, same encoding
- count_dec  out  CNT_WIDTH  decoded count = tens*10 + units
- seg_valid  out  1  both digits decoded to 0-9
- phase  out  2  tracked phase: 0 IDLE, 1 GREEN, 2 YELLOW, 3 RED
- phase_done  out  1  one-cycle pulse on a legal phase exit
- err_onehot  out  1  pulse: lamp pattern not one-hot while en
- err_seq  out  1  pulse: illegal phase transition
- err_count  out  1  pulse: countdown mismatch
- err_dur  out  1  pulse: phase length wrong
- err_seg  out  1  pulse: undecodable segment pattern
- err_sticky  out  1  OR of all error pulses since rst or clr_err
- err_total  out  ERR_CNT_WIDTH  count of error-pulse cycles, saturating

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs are 0 and phase=IDLE. Internal sample registers and counters clear. Reset mid-operation aborts all tracking immediately.
- Stage 1 registers all inputs. All outputs are registered from stage 1, so latency is 2 cycles from input to flag.
- Segment decode:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Any other pattern sets digit invalid, seg_valid=0 and pulses err_seg (only while en).
  - A decoded value above 2^CNT_WIDTH-1 is also invalid.
  - count_dec holds its last valid value while seg_valid=0.
- Disabled (registered en low): phase goes to IDLE, no checks, duration counter clears.
- Lamp decode: exactly one lamp must be lit while en; otherwise pulse err_onehot and skip the sequence, count and duration checks that cycle.
- Phase FSM:
  - IDLE to the lit phase on the first valid sample. If that phase is not GREEN, pulse err_seq.
  - Legal transitions: GREEN to YELLOW, YELLOW to RED, RED to GREEN.
  - Any other lamp change pulses err_seq, and the FSM resyncs to the observed phase.
- Count check (only when seg_valid, previous sample valid, and same phase):
  - count_dec must equal prev-1.
  - prev=0 with the same phase still lit is a stall and pulses err_count.
- Phase-change count check:
  - prev count must be 0.
  - New count must equal the INIT value of the new phase.
  - Either violation pulses err_count.
- Duration:
  - dur counter resets to 1 at phase entry, increments per sample, and saturates at all-ones.
  - On a legal exit, dur must equal INIT+1 of the exited phase, else pulse err_dur.
  - The first phase after IDLE is exempt from the duration check.
- phase_done pulses on every legal exit regardless of err_dur.
- Simultaneous errors: several err_* pulses may assert in the same cycle. err_total increments by 1 per cycle with any pulse.
- err_sticky and err_total clear on clr_err. If clr_err coincides with a new error, the error wins: err_sticky=1, err_total=1.
- err_total saturates at all-ones.

Optional Feature:
- Macro: TRAFFIC_MON_CYCLE_STATS_EN.
- Defined: adds output full_cycles[15:0]. It increments when RED to GREEN completes a G, Y, R sequence with no error pulses during that sequence, wraps at 0xFFFF, and clears on rst.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset then en=1, drive a legal stream: GREEN counting 14 down to 0 (15 cycles), YELLOW 2 to 0 (3), RED 17 to 0 (18), repeated twice -> no err_*, phase_done 6 times, err_total=0.
- Mid-GREEN, drive count 9 after 11 -> err_count one pulse 2 cycles later, err_sticky=1, err_total=1.
- Switch GREEN to RED at count 0 -> err_seq pulse, phase=3, following RED countdown checked normally.
- Drive Red and Green both high for 1 cycle -> err_onehot pulse, no err_seq or err_count that cycle; assert clr_err -> err_sticky=0, err_total=0.
- seg_b=0000001 for 1 cycle -> err_seg, seg_valid=0, count_dec holds the previous value.
- Hold YELLOW at 0 for 2 extra cycles then go RED=17 -> err_count (stall) and err_dur (5≠3); assert rst mid-RED -> all outputs 0, phase=IDLE next cycle.
